// File: rtl/tanh_seq_ctrl.sv
// Sequencer for the hyperbolic CORDIC core and shared divider computing tanh = sinh/cosh.
// One operand in flight; control outputs are registered and forced low while rst is high.
module tanh_seq_ctrl #(
  parameter int W      = 32,
  parameter int ITER   = 16,
  parameter int REP1   = 4,
  parameter int REP2   = 13,
  parameter int DIV_TO = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_x,
  output logic         core_load,
  output logic [W-1:0] core_x,
  output logic         core_step,
  output logic [4:0]   core_shift,
  output logic         div_start,
  input  logic         div_done,
  input  logic [W-1:0] div_q,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_tanh,
  output logic         res_err,
  output logic         busy
);

  localparam bit       R1EN  = (REP1 <= ITER);
  localparam bit       R2EN  = (REP2 <= ITER);
  localparam int       STEPS = ITER + (R1EN ? 1 : 0) + (R2EN ? 1 : 0);
  localparam int       SW    = $clog2(STEPS + 1);
  localparam int       CW    = $clog2(DIV_TO + 1);
  localparam logic [4:0] R1  = 5'(REP1);
  localparam logic [4:0] R2  = 5'(REP2);

  typedef enum logic [2:0] {IDLE, LOAD, ROT, START, WAIT, RESP} state_t;

  state_t        state;
  logic [W-1:0]  x_q;
  logic          load_q;
  logic          step_q;
  logic [4:0]    shift_q;
  logic          rep_done;
  logic [SW-1:0] steps_left;
  logic          start_q;
  logic [CW-1:0] tmo_q;
  logic          valid_q;
  logic [W-1:0]  tanh_q;
  logic          err_q;
  logic          is_rep;

  // Convergence requires shift indices REP1 and REP2 to be issued twice in a row.
  assign is_rep = (R1EN && shift_q == R1) || (R2EN && shift_q == R2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x_q        <= '0;
      load_q     <= 1'b0;
      step_q     <= 1'b0;
      shift_q    <= '0;
      rep_done   <= 1'b0;
      steps_left <= '0;
      start_q    <= 1'b0;
      tmo_q      <= '0;
      valid_q    <= 1'b0;
      tanh_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            x_q    <= req_x;
            load_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          load_q     <= 1'b0;
          step_q     <= 1'b1;
          shift_q    <= 5'd1;
          rep_done   <= 1'b0;
          steps_left <= SW'(STEPS - 1);
          state      <= ROT;
        end
        ROT: begin
          if (steps_left == '0) begin
            step_q  <= 1'b0;
            shift_q <= '0;
            start_q <= 1'b1;
            state   <= START;
          end else begin
            steps_left <= steps_left - SW'(1);
            if (is_rep && !rep_done) begin
              rep_done <= 1'b1;
            end else begin
              shift_q  <= shift_q + 5'd1;
              rep_done <= 1'b0;
            end
          end
        end
        START: begin
          start_q <= 1'b0;
          tmo_q   <= CW'(DIV_TO);
          state   <= WAIT;
        end
        WAIT: begin
          // A done arriving on the expiry cycle still delivers a valid quotient.
          tmo_q <= tmo_q - CW'(1);
          if (div_done) begin
            tanh_q  <= div_q;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= RESP;
          end else if (tmo_q <= CW'(1)) begin
            tanh_q  <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = !rst && (state == IDLE);
  assign busy       = !rst && (state != IDLE);
  assign core_load  = !rst && load_q;
  assign core_step  = !rst && step_q;
  assign core_shift = rst ? '0 : shift_q;
  assign core_x     = rst ? '0 : x_q;
  assign div_start  = !rst && start_q;
  assign res_valid  = !rst && valid_q;
  assign res_tanh   = rst ? '0 : tanh_q;
  assign res_err    = !rst && err_q;

endmodule

// File: tb/tb_tanh_seq_ctrl.sv
// Self-checking bench for tanh_seq_ctrl: table-driven and random operations checked
// cycle by cycle against a schedule/timing model, plus reset and ITER=12 back-to-back sequences.
module tb_tanh_seq_ctrl;

  localparam int W      = 32;
  localparam int DIV_TO = 64;
  localparam int REP1   = 4;
  localparam int REP2   = 13;

  typedef int intq_t[$];

  typedef struct {
    logic [31:0] x;
    int          delay;
    logic [31:0] q;
    int          hold;
    bit          spur;
    bit          expErr;
    logic [31:0] expTanh;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         req_valid, req_ready;
  logic [W-1:0] req_x;
  logic         core_load, core_step, div_start, div_done;
  logic [W-1:0] core_x, div_q, res_tanh;
  logic [4:0]   core_shift;
  logic         res_valid, res_ready, res_err, busy;

  logic         b_rst;
  logic         b_req_valid, b_req_ready;
  logic [W-1:0] b_req_x;
  logic         b_core_load, b_core_step, b_div_start, b_div_done;
  logic [W-1:0] b_core_x, b_div_q, b_res_tanh;
  logic [4:0]   b_core_shift;
  logic         b_res_valid, b_res_ready, b_res_err, b_busy;

  int errors = 0;
  int checks = 0;
  intq_t sched16, sched12;
  vec_t vecs[8];

  tanh_seq_ctrl #(.W(W), .ITER(16), .REP1(REP1), .REP2(REP2), .DIV_TO(DIV_TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
    .core_load(core_load), .core_x(core_x), .core_step(core_step), .core_shift(core_shift),
    .div_start(div_start), .div_done(div_done), .div_q(div_q), .res_valid(res_valid),
    .res_ready(res_ready), .res_tanh(res_tanh), .res_err(res_err), .busy(busy)
  );

  tanh_seq_ctrl #(.W(W), .ITER(12), .REP1(REP1), .REP2(REP2), .DIV_TO(DIV_TO)) dut12 (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_x(b_req_x),
    .core_load(b_core_load), .core_x(b_core_x), .core_step(b_core_step), .core_shift(b_core_shift),
    .div_start(b_div_start), .div_done(b_div_done), .div_q(b_div_q), .res_valid(b_res_valid),
    .res_ready(b_res_ready), .res_tanh(b_res_tanh), .res_err(b_res_err), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift schedule: every index 1..iter once, REP1/REP2 twice when they lie within range.
  function automatic intq_t buildSched(input int iter);
    intq_t s;
    for (int i = 1; i <= iter; i++) begin
      s.push_back(i);
      if (i == REP1 || i == REP2) s.push_back(i);
    end
    return s;
  endfunction

  function automatic logic [42:0] expVec(input bit rdy, input bit bsy, input bit ld, input bit stp,
                                         input logic [4:0] sh, input bit st, input bit vld,
                                         input logic [31:0] x);
    return {rdy, bsy, ld, stp, sh, st, vld, x};
  endfunction

  function automatic logic [42:0] actVec();
    return {req_ready, busy, core_load, core_step, core_shift, div_start, res_valid, core_x};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are sampled at the falling edge.
  task automatic applyStimulus(input bit v, input logic [31:0] x, input bit dd, input logic [31:0] dq,
                               input bit rr, input bit r);
    @(posedge clk);
    #1;
    req_valid = v;
    req_x     = x;
    div_done  = dd;
    div_q     = dq;
    res_ready = rr;
    rst       = r;
    @(negedge clk);
  endtask

  task automatic doOp(input int id, input vec_t v);
    int sc, respCycle, endCycle, bound;
    bit done, dd, rv, vld;
    logic [31:0] dq;
    logic [4:0] sh;
    logic [42:0] expO;
    bound = 0;
    while (!req_ready && bound < 200) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      bound++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL op%0d_idle_wait: got req_ready=0 expected 1 within 200 cycles", id);
      return;
    end
    applyStimulus(1'b1, v.x, 1'b0, $urandom, 1'b0, 1'b0);
    checkOutput($sformatf("op%0d_accept", id), 64'(req_ready), 64'd1);
    sc        = sched16.size() + 2;
    respCycle = sc + ((v.delay >= 1 && v.delay <= DIV_TO) ? v.delay + 1 : DIV_TO + 1);
    endCycle  = respCycle + v.hold;
    for (int c = 1; c <= endCycle + 1; c++) begin
      done = (v.delay > 0) && (c == sc + v.delay);
      dd   = done || (v.spur && (c == 5 || c == 11 || c == sc));
      dq   = done ? v.q : $urandom;
      rv   = (c <= endCycle) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(rv, $urandom, dd, dq, c >= endCycle, 1'b0);
      if (c <= endCycle) begin
        vld  = (c >= respCycle);
        sh   = (c >= 2 && c <= sc - 1) ? 5'(sched16[c-2]) : 5'd0;
        expO = expVec(1'b0, 1'b1, c == 1, c >= 2 && c <= sc - 1, sh, c == sc, vld, v.x);
      end else begin
        vld  = 1'b0;
        expO = expVec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, v.x);
      end
      checkOutput($sformatf("op%0d_c%0d_ctrl", id, c), 64'(actVec()), 64'(expO));
      if (vld) checkOutput($sformatf("op%0d_c%0d_result", id, c), {31'd0, res_err, res_tanh},
                           {31'd0, v.expErr, v.expTanh});
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;
    int startCyc, hsCyc, stepIdx, ops;
    rst = 1'b1; req_valid = 1'b0; req_x = '0; div_done = 1'b0; div_q = '0; res_ready = 1'b0;
    b_rst = 1'b1; b_req_valid = 1'b0; b_req_x = '0; b_div_done = 1'b0; b_div_q = '0; b_res_ready = 1'b0;
    sched16 = buildSched(16);
    sched12 = buildSched(12);

    vecs[0] = '{32'h1234_5678, 5,  32'h0C4B_0000, 0,  1'b0, 1'b0, 32'h0C4B_0000};
    vecs[1] = '{32'h0000_8000, 5,  32'h0ABC_DEF0, 10, 1'b0, 1'b0, 32'h0ABC_DEF0};
    vecs[2] = '{32'hFFFF_C000, 0,  32'h5555_5555, 0,  1'b0, 1'b1, 32'h0};
    vecs[3] = '{32'h0001_0000, 3,  32'hFFFF_0001, 2,  1'b0, 1'b0, 32'hFFFF_0001};
    vecs[4] = '{32'h2000_0000, 3,  32'h0600_1234, 0,  1'b1, 1'b0, 32'h0600_1234};
    vecs[5] = '{32'h7FFF_FFFF, 1,  32'h7FFF_FFFF, 1,  1'b0, 1'b0, 32'h7FFF_FFFF};
    vecs[6] = '{32'h0F0F_0F0F, 64, 32'h1357_9BDF, 0,  1'b0, 1'b0, 32'h1357_9BDF};
    vecs[7] = '{32'h8000_0000, 65, 32'h2468_ACE0, 0,  1'b1, 1'b1, 32'h0};

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
      checkOutput($sformatf("reset_outs%0d", i), {20'd0, actVec(), 1'b0},
                  {20'd0, 43'd0, 1'b0});
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("reset_idle", 64'(actVec()), 64'(expVec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0)));

    for (int i = 0; i < 8; i++) doOp(i, vecs[i]);

    for (int i = 0; i < 6; i++) begin
      rv.x       = $urandom;
      rv.delay   = $urandom_range(1, 70);
      rv.q       = $urandom;
      rv.hold    = $urandom_range(0, 4);
      rv.spur    = 1'($urandom_range(0, 1));
      rv.expErr  = (rv.delay > DIV_TO);
      rv.expTanh = rv.expErr ? 32'h0 : rv.q;
      doOp(10 + i, rv);
    end

    // Reset in the middle of the rotation schedule aborts the operation without a result.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) applyStimulus(1'b0, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("pre_reset_shift", 64'({core_step, core_shift}), 64'({1'b1, 5'(sched16[5])}));
    applyStimulus(1'b0, $urandom, 1'b1, $urandom, 1'b1, 1'b1);
    checkOutput("midrot_reset_outs", {20'd0, actVec(), res_err}, 64'd0);
    checkOutput("midrot_reset_res", 64'(res_tanh), 64'd0);
    applyStimulus(1'b0, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("post_reset_idle", 64'(actVec()),
                64'(expVec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0)));
    for (int c = 0; c < 25; c++) begin
      applyStimulus(1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0);
      checkOutput($sformatf("post_reset_quiet%0d", c), 64'({res_valid, busy}), 64'd0);
    end
    doOp(100, vecs[0]);

    // ITER=12 build with req_valid and res_ready held high: back-to-back operations.
    b_rst = 1'b0; b_req_valid = 1'b1; b_res_ready = 1'b1;
    startCyc = -100; hsCyc = -100; stepIdx = 0; ops = 0;
    for (int cyc = 0; cyc < 200 && ops < 3; cyc++) begin
      @(posedge clk);
      #1;
      b_div_done = (cyc == startCyc + 2);
      b_div_q    = 32'hA000_0000 | 32'(ops);
      b_req_x    = $urandom;
      @(negedge clk);
      if (b_core_load) begin
        if (hsCyc >= 0) checkOutput($sformatf("b2b_accept%0d", ops), 64'(cyc), 64'(hsCyc + 2));
        stepIdx = 0;
      end
      if (b_core_step) begin
        checkOutput($sformatf("b_shift%0d_%0d", ops, stepIdx), 64'(b_core_shift),
                    64'(stepIdx < sched12.size() ? sched12[stepIdx] : 0));
        stepIdx++;
      end
      if (b_div_start) begin
        checkOutput($sformatf("b_steps%0d", ops), 64'(stepIdx), 64'(sched12.size()));
        startCyc = cyc;
      end
      if (b_res_valid) begin
        checkOutput($sformatf("b_resp_lat%0d", ops), 64'(cyc), 64'(startCyc + 3));
        checkOutput($sformatf("b_result%0d", ops), {31'd0, b_res_err, b_res_tanh},
                    {31'd0, 1'b0, 32'hA000_0000 | 32'(ops)});
        hsCyc = cyc;
        ops++;
      end
    end
    checkOutput("b_ops_done", 64'(ops), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tanh_seq_ctrl.md
Name: tanh_seq_ctrl

Overview:
Sequencer for the iterative hyperbolic CORDIC core and the shared divider that together produce tanh = sinh/cosh.
- Accepts one operand at a time over a valid/ready request port.
- Loads the core, then issues the hyperbolic iteration schedule, including the mandatory repeated iterations.
- Launches the divider with a start/done handshake and a timeout.
- Returns the quotient on a valid/ready result port.

Parameters:
- W, 32, operand and result width (fixed-point, same format as the core).
- ITER, 16, highest CORDIC shift index; indices 1..ITER are issued.
- REP1, 4, first shift index issued twice.
- REP2, 13, second shift index issued twice; it is ignored if greater than ITER.
- DIV_TO, 64, maximum cycles waited for div_done before an error is flagged.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  operand available.
- req_ready  out  1  controller can accept an operand.
- req_x  in  W  operand x.
- core_load  out  1  one-cycle pulse: core initialises its x/y/z registers from core_x.
- core_x  out  W  latched operand driven to the core.
- core_step  out  1  core performs one micro-rotation this cycle.
- core_shift  out  5  shift index for the current step.
- div_start  out  1  one-cycle pulse: divider samples cosh/sinh from the core.
- div_done  in  1  divider result valid (sampled only in WAIT).
- div_q  in  W  divider quotient.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_tanh  out  W  result.
- res_err  out  1  divider timed out; res_tanh is 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: on any clk edge with rst=1, the block enters IDLE and clears every register. While rst=1, all outputs are 0, including req_ready. Reset mid-operation aborts that operation with no result.
- STEPS = ITER + (REP1 <= ITER) + (REP2 <= ITER). With defaults, STEPS = 18.

States and transitions:
- IDLE: req_ready=1. When req_valid=1, latch req_x into core_x and go to LOAD.
- LOAD: core_load=1 for exactly 1 cycle, then go to ROT.
- ROT: core_step=1 on each of STEPS consecutive cycles.
  - core_shift follows 1, 2, 3, 4, 4, 5, …, 13, 13, 14, …, ITER; a repeated index appears on two consecutive cycles.
  - After the last step, go to START.
- START: div_start=1 for 1 cycle. Load the timeout counter with DIV_TO, then go to WAIT.
- WAIT: decrement the timeout counter each cycle.
  - If div_done=1: capture div_q into res_tanh, set res_err=0, go to RESP.
  - Else, if the counter reaches 0: set res_tanh=0, res_err=1, go to RESP.
  - If div_done arrives on the same cycle the counter expires, div_done wins.
- RESP: res_valid=1. res_tanh and res_err are held stable until res_valid && res_ready, then go to IDLE.

Cycle-level rules:
- Only one request is in flight; req_ready=0 in every state except IDLE.
- If the request is accepted at edge 0: core_load is high in cycle 1; core_step is high in cycles 2..STEPS+1; div_start is high in cycle STEPS+2.
- If div_done is first seen in WAIT cycle k, res_valid is asserted in cycle k+1.
- A back-to-back request may be accepted in the first IDLE cycle after the RESP handshake, so each result handshake is followed by at least one dead cycle.
- div_done outside WAIT (including during START) is ignored.
- core_step, core_load and div_start are never asserted in the same cycle.
- core_shift = 0 whenever core_step = 0.
- req_x is sampled only at acceptance; later changes have no effect. core_x holds its value until the next acceptance.

Test Plan:
- Single op, defaults, divider model with done 5 cycles after start, q=32'h0C4B_0000:
  - Request accepted at cycle 0.
  - core_load at cycle 1; 18 core_step cycles at 2..19 with shift sequence 1,2,3,4,4,5..13,13,14,15,16.
  - div_start at cycle 20; res_valid at cycle 26 with res_tanh=32'h0C4B_0000, res_err=0.
- Backpressure: res_ready held 0 for 10 cycles after res_valid → res_valid, res_tanh and res_err are stable for all 10 cycles; req_ready=0 throughout; the handshake is followed by IDLE.
- Timeout: divider never asserts done, DIV_TO=64 → res_valid with res_err=1 and res_tanh=0, 65 cycles after div_start; next op completes normally.
- Spurious div_done pulses during ROT and START, real done 3 cycles after start → spurious pulses have no effect; result captured from the real done only.
- Reset mid-ROT (rst high at step 7 for 1 cycle) → all outputs 0 during reset; IDLE with req_ready=1 next cycle; no res_valid; a fresh op then produces the full 18-step schedule.
- ITER=12 build → STEPS=13; schedule is 1..4,4,5..12 with no repeat of 13; back-to-back requests, with req_valid held high, are accepted one cycle after each result handshake.
